lcd_frame_capture: RTL
======================

Name: lcd_frame_capture

Overview:
- Receives the SM510 LCD drive outputs: commons H (one-hot), segment planes segA/segB, and Bs.
- Rebuilds a complete 4-common x 32-segment (+4 Bs) frame image in clk domain.
- Exposes the frame through a registered random-access read port for the video/overlay renderer.
- Double-buffered, so the renderer always reads a complete, coherent frame.

Parameters:
- SETTLE, 4: clk cycles h/seg inputs must be stable after a common change before a row is captured (min 2).
- TIMEOUT_W, 20: width of the stall counter; no valid row capture for 2^TIMEOUT_W clk cycles declares the display stalled.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- h  in  4  LCD common outputs, one-hot
- seg_a  in  16  segment plane A for the active common
- seg_b  in  16  segment plane B for the active common
- bs  in  1  Bs segment for the active common
- rd_com  in  2  read common index 0-3
- rd_seg  in  5  read segment index; 0-15 = seg_a bit, 16-31 = seg_b bit (index-16)
- rd_data  out  1  segment state from display buffer, 1-cycle latency
- bs_row  out  4  display-buffer Bs; bit c = Bs captured with common c
- frame_done  out  1  one-cycle pulse when a new frame is committed
- frame_cnt  out  8  committed-frame counter, wraps 255->0
- seq_err  out  1  one-cycle pulse on an out-of-order common
- stalled  out  1  high while the display is stalled

Behaviour:
- Reset (rst=0 at posedge clk): all outputs 0; shadow and display buffers 0; sync flops 0; FSM in WAIT0; settle and stall counters 0.
- Input sync: h, seg_a, seg_b, bs pass through 2 flops (sync stage s1, s2). All logic uses s2. Input-to-capture latency is 2 + SETTLE cycles.
- Settle detect: counter resets to 0 whenever s2 h or s2 seg/bs differs from the previous cycle, otherwise increments, saturating at SETTLE.
- Row capture: a capture event fires exactly once, when the counter reaches SETTLE-1 -> SETTLE.
  - The event is accepted only if h is one-hot.
  - h=0000 or multi-hot: ignored; the FSM state is kept.
  - Common c = log2(h).
- FSM states WAIT0, ROW1, ROW2, ROW3:
  - WAIT0: capture c=0 -> write shadow row 0, go to ROW1. Any other c -> ignored, no error.
  - ROWn (n=1..3): capture c=n -> write shadow row n.
    - n<3: go to ROW(n+1).
    - n=3: commit shadow to display, pulse frame_done, increment frame_cnt, go to WAIT0.
  - ROWn, capture c=n-1: duplicate row; rewrite shadow row n-1, stay in ROWn, no error.
  - ROWn, capture c=0: pulse seq_err, rewrite row 0, go to ROW1.
  - ROWn, any other c: pulse seq_err, go to WAIT0.
- Commit: all 128 segment bits and 4 Bs bits copy in one cycle, in the same cycle row 3 is written (the row-3 data is included). frame_done is asserted the cycle after the commit edge.
- Read port: rd_data registered. The value reflects the display buffer at the edge that samples rd_com/rd_seg. A read in the commit cycle returns old data; the next cycle returns new data.
- Stall:
  - Counter clears on every accepted capture; otherwise it increments.
  - At all-ones: set stalled, clear the display buffer and bs_row to 0, hold the counter.
  - The next accepted capture clears stalled. Display data stays 0 until the next commit.
  - Covers the CPU halt and BP=0 blanking cases.
- Reset mid-frame: the partial shadow is discarded; no frame_done.

Optional Feature:
- Macro: LCD_FRAME_CAPTURE_PERSIST_EN.
- Defined: a previous-frame buffer (128+4 bits) is loaded with the old display contents at each commit.
  - rd_data and bs_row become display OR previous, emulating LCD segment persistence and suppressing one-frame flicker.
  - Stall clears both buffers.
- Undefined: no previous buffer; rd_data/bs_row come from the display buffer only.

Test Plan:
- Reset: hold rst=0 10 cycles with random inputs -> rd_data=0, bs_row=0, frame_cnt=0, all pulses 0.
- Normal frame: drive h=0001/0010/0100/1000 for 50 cycles each, with seg_a=16'h0001<<c, seg_b=16'h8000>>c, bs=c[0].
  - Expect one frame_done after the 4th row; frame_cnt=1; bs_row=4'b1010.
  - rd_com=2, rd_seg=2 -> 1; rd_com=2, rd_seg=29 -> 1; rd_com=2, rd_seg=3 -> 0.
- Glitch: h=0010 for SETTLE-1 cycles inside a 0001 row -> no capture, no seq_err; frame completes normally.
- Sequence error: rows 0,1,3 -> seq_err pulse on row 3, no frame_done; the following full 0..3 sequence commits frame_cnt=1.
- Stall: after a committed frame, hold h=0001 with no changes for 2^TIMEOUT_W cycles (TIMEOUT_W=8 in the bench) -> stalled=1, all rd_data=0. The next valid row clears stalled.
- Persist (macro defined): frame A with seg_a bit 5 set on row 0, then frame B with it clear -> rd_com=0, rd_seg=5 reads 1 after B. After frame C (also clear) it reads 0. With the macro undefined, it reads 0 after B.

Source files
------------

// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture: rebuilds the SM510 LCD frame (4 commons x 32 segments
// plus 4 Bs bits) from the raw common/segment drive lines. Rows are captured
// once the synchronised inputs have settled, assembled in a shadow buffer and
// committed to a display buffer in one cycle when row 3 arrives. The renderer
// reads the display buffer through a registered port with 1-cycle latency.
//
// Optional build macro LCD_FRAME_CAPTURE_PERSIST_EN: keeps the previously
// committed frame and ORs it into rd_data/bs_row, emulating LCD segment
// persistence so a segment that blinks off for a single frame does not flicker.
module lcd_frame_capture #(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  h,
  input  logic [15:0] seg_a,
  input  logic [15:0] seg_b,
  input  logic        bs,
  input  logic [1:0]  rd_com,
  input  logic [4:0]  rd_seg,
  output logic        rd_data,
  output logic [3:0]  bs_row,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        seq_err,
  output logic        stalled
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE);
  localparam logic [SW-1:0] SET_PRE = SW'(SETTLE - 1);

  // Row state: WAIT0 waits for common 0, ROWn waits for common n.
  typedef enum logic [1:0] {WAIT0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2, ROW3 = 2'd3} state_t;

  // Packed input vector: {bs, seg_b, seg_a, h}
  logic [36:0] r_s1, r_s2, r_prev;
  logic [SW-1:0] r_settle;
  state_t        r_state, w_next;
  logic [3:0][31:0] r_shadow, r_disp;
  logic [3:0]       r_shadow_bs, r_disp_bs;
  logic [TIMEOUT_W-1:0] r_stall_cnt;
  logic        r_rd_data, r_frame_done, r_seq_err, r_stalled;
  logic [7:0]  r_frame_cnt;

  logic        w_change, w_cap, w_onehot, w_accept, w_stall_hit;
  logic [3:0]  w_h;
  logic [1:0]  w_com, w_cur;
  logic [31:0] w_row;
  logic        w_bs;
  logic        w_wr_en, w_commit, w_err;
  logic [1:0]  w_wr_idx;
  logic        w_rd_bit;
  logic [3:0]  w_bs_out;

  // Two-flop synchroniser plus one-cycle history for change detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= {bs, seg_b, seg_a, h};
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_change = (r_s2 != r_prev);
  assign w_h      = r_s2[3:0];
  assign w_row    = r_s2[35:4];
  assign w_bs     = r_s2[36];

  // Settle counter: restarts on any input change, saturates at SETTLE.
  always_ff @(posedge clk) begin
    if (!rst)                  r_settle <= '0;
    else if (w_change)         r_settle <= '0;
    else if (r_settle != SET_MAX) r_settle <= r_settle + 1'b1;
  end

  // A row is captured exactly once, on the step from SETTLE-1 to SETTLE.
  assign w_cap    = !w_change && (r_settle == SET_PRE);
  assign w_onehot = (w_h != 4'd0) && ((w_h & (w_h - 4'd1)) == 4'd0);
  assign w_accept = w_cap && w_onehot;
  assign w_cur    = r_state;

  // Common index from the one-hot h.
  always_comb begin
    w_com = 2'd0;
    case (w_h)
      4'b0010: w_com = 2'd1;
      4'b0100: w_com = 2'd2;
      4'b1000: w_com = 2'd3;
      default: w_com = 2'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= WAIT0;
    else      r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      if (r_state == WAIT0) begin
        if (w_com == 2'd0) w_next = ROW1;
      end else if (w_com == w_cur) begin
        w_next = (r_state == ROW3) ? WAIT0 : state_t'(w_cur + 2'd1);
      end else if (w_com == w_cur - 2'd1) begin
        w_next = r_state;
      end else if (w_com == 2'd0) begin
        w_next = ROW1;
      end else begin
        w_next = WAIT0;
      end
    end
  end

  // FSM outputs: shadow write, commit and sequence-error strobes.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = w_com;
    w_commit = 1'b0;
    w_err    = 1'b0;
    if (w_accept) begin
      if (r_state == WAIT0) begin
        w_wr_en = (w_com == 2'd0);
      end else if (w_com == w_cur) begin
        w_wr_en  = 1'b1;
        w_commit = (r_state == ROW3);
      end else if (w_com == w_cur - 2'd1) begin
        w_wr_en = 1'b1;
      end else begin
        w_err   = 1'b1;
        w_wr_en = (w_com == 2'd0);
      end
    end
  end

  // Shadow buffer: assembles the frame row by row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow    <= '0;
      r_shadow_bs <= '0;
    end else if (w_wr_en) begin
      r_shadow[w_wr_idx]    <= w_row;
      r_shadow_bs[w_wr_idx] <= w_bs;
    end
  end

  // Stall watchdog: any accepted capture proves the display is alive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_stalled   <= 1'b0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
      r_stalled   <= 1'b0;
    end else if (w_stall_hit) begin
      r_stalled   <= 1'b1;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign w_stall_hit = !w_accept && (r_stall_cnt == {TIMEOUT_W{1'b1}});

  // Display buffer: whole-frame commit including the row-3 data arriving now.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp    <= '0;
      r_disp_bs <= '0;
    end else if (w_commit) begin
      r_disp[0] <= r_shadow[0];
      r_disp[1] <= r_shadow[1];
      r_disp[2] <= r_shadow[2];
      r_disp[3] <= w_row;
      r_disp_bs <= {w_bs, r_shadow_bs[2:0]};
    end else if (w_stall_hit) begin
      r_disp    <= '0;
      r_disp_bs <= '0;
    end
  end

`ifdef LCD_FRAME_CAPTURE_PERSIST_EN
  logic [3:0][31:0] r_pdisp;
  logic [3:0]       r_pdisp_bs;

  // Previous-frame buffer: takes the outgoing display contents on commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pdisp    <= '0;
      r_pdisp_bs <= '0;
    end else if (w_commit) begin
      r_pdisp    <= r_disp;
      r_pdisp_bs <= r_disp_bs;
    end else if (w_stall_hit) begin
      r_pdisp    <= '0;
      r_pdisp_bs <= '0;
    end
  end

  assign w_rd_bit = r_disp[rd_com][rd_seg] | r_pdisp[rd_com][rd_seg];
  assign w_bs_out = r_disp_bs | r_pdisp_bs;
`else
  assign w_rd_bit = r_disp[rd_com][rd_seg];
  assign w_bs_out = r_disp_bs;
`endif

  // Registered read port and event pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data    <= 1'b0;
      r_frame_done <= 1'b0;
      r_seq_err    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_rd_data    <= w_rd_bit;
      r_frame_done <= w_commit;
      r_seq_err    <= w_err;
      if (w_commit) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign rd_data    = r_rd_data;
  assign bs_row     = w_bs_out;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign seq_err    = r_seq_err;
  assign stalled    = r_stalled;

endmodule
